// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer and lock supervisor running on the free-running reference clock.
// Times the PLL reset pulse, qualifies lock over a stability window, retries on timeout.
module pll_lock_ctrl #(
  parameter int RST_CYCLES         = 64,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int MAX_RETRIES        = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [7:0]       loss_d;
  logic             locked_p0, locked_p1;
  logic             locked_s;

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      locked_p0 <= locked;
      locked_p1 <= locked_p0;
    end
  end

  assign locked_s = locked_p1;

  always_comb begin
    state_d = state_q;
    rty_d   = rty_q;
    loss_d  = lock_loss_cnt;
    case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          rty_d   = rty_q + RTY_W'(1);
          state_d = (rty_d == RTY_MAX) ? ST_FAIL : ST_RESET;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          rty_d   = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          loss_d  = sat_inc(lock_loss_cnt);
          state_d = ST_RESET;
        end
      end
      ST_FAIL: ;
      default: state_d = ST_RESET;
    endcase
    // A relock request overrides everything except the loss bookkeeping above
    if (relock_req) begin
      state_d = ST_RESET;
      rty_d   = '0;
    end
    cnt_d = ((state_d != state_q) || relock_req) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs are registered from the next state so they move on the transition edge
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      cnt_q         <= '0;
      rty_q         <= '0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rty_q         <= rty_d;
      lock_loss_cnt <= loss_d;
      pll_rst       <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      ready         <= (state_d == ST_RUN);
      fail          <= (state_d == ST_FAIL);
    end
  end

  assign state = state_q;

endmodule
